// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-value UART transmitter.
package count_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/count_uart_tx_if.sv
// Byte handshake between the counter output bus and the UART transmitter.
interface count_uart_tx_if;
   import count_uart_pkg::*;

   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last and
// second-to-last cycle of each bit; held at zero while clear_i is high.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic tick_c_o,
   output logic pre_tick_c_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_c_o     = !clear_i && (cnt_q == CNT_LAST);
   assign pre_tick_c_o = !clear_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/count_uart_tx.sv
// UART 8N1 transmitter for the counter value; define COUNT_UART_PARITY_EN
// to insert an even-parity bit (8E1).
module count_uart_tx
   import count_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic            clk,
   input  logic            rst,
   count_uart_tx_if.slave  in_if,
   output logic            tx,
   output logic            busy,
   output logic            frame_done
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   state_e               state_q, state_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
`ifdef COUNT_UART_PARITY_EN
   logic                 par_q, par_d;
`endif
   logic                 tick_c;
   logic                 pre_tick_c;
   logic                 idle_c;

   assign idle_c          = (state_q == IDLE);
   assign in_if.in_ready  = idle_c;

   // Divider stays cleared while idle, so every frame starts on a fresh bit period.
   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (idle_c),
      .tick_c_o     (tick_c),
      .pre_tick_c_o (pre_tick_c)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef COUNT_UART_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_if.in_valid) begin
               shift_d = in_if.in_data;
               idx_d   = '0;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
`ifdef COUNT_UART_PARITY_EN
               par_d   = ^in_if.in_data;
`endif
            end
         end
         START: begin
            if (tick_c) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            // Shift register consumed LSB first; shift_q[0] is always the bit on the line.
            if (tick_c) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
`ifdef COUNT_UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = IDLE_LEVEL;
`endif
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef COUNT_UART_PARITY_EN
         PARITY: begin
            if (tick_c) begin
               state_d = STOP;
               tx_d    = IDLE_LEVEL;
            end
         end
`endif
         STOP: begin
            // Registered pulse lands in the final stop-bit cycle.
            if (pre_tick_c) begin
               done_d = 1'b1;
            end
            if (tick_c) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         shift_q <= '0;
         idx_q   <= '0;
`ifdef COUNT_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
`ifdef COUNT_UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
